// File: rtl/reg_scoreboard.sv
// Register hazard scoreboard: per-register pending-write counters gate the decode grant.
// Grant is combinational from registered counts (no release bypass); claims/releases land on the next edge.
module reg_scoreboard #(
   parameter int BITSIZE = 32,
   parameter int NREGS   = 32,
   parameter int CNT_W   = 2,
   parameter int PEND_W  = 6
) (
   input  logic              clk,
   input  logic              resetn_i,
   input  logic              ID_SB_req_i,
   input  logic [4:0]        ID_SB_rs1_i,
   input  logic [4:0]        ID_SB_rs2_i,
   input  logic [4:0]        ID_SB_rd_i,
   input  logic              ID_SB_rd_we_i,
   output logic              SB_ID_access_o,
   input  logic              WB_SB_release_i,
   input  logic [4:0]        WB_SB_rd_i,
   input  logic              flush_i,
   output logic [PEND_W-1:0] pending_o,
   output logic              err_o
);

   // 5-bit indices reach at most 32 registers; BITSIZE is referenced only for uniformity.
   localparam int NTRK = ((NREGS < 32) ? NREGS : 32) + 0 * BITSIZE;
   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [CNT_W-1:0]  cnt_q [NTRK];
   logic [CNT_W-1:0]  cnt_d [NTRK];
   logic [PEND_W-1:0] pending_q, pending_d;
   logic              err_q, err_d;

   logic              rs1_free, rs2_free, rd_room, grant;
   logic              claim, rel_req, rel_ok, rel_err;
   logic [CNT_W-1:0]  rel_cnt;

   function automatic logic [CNT_W-1:0] cnt_of(input logic [4:0] r);
      cnt_of = '0;
      if (r != 5'd0 && int'(r) < NTRK)
         cnt_of = cnt_q[r];
   endfunction

   assign rs1_free = (cnt_of(ID_SB_rs1_i) == '0);
   assign rs2_free = (cnt_of(ID_SB_rs2_i) == '0);
   assign rd_room  = !ID_SB_rd_we_i || (ID_SB_rd_i == 5'd0) || (cnt_of(ID_SB_rd_i) != CNT_MAX);
   // Gated by the async reset so the grant drops the instant reset asserts.
   assign grant    = resetn_i & ID_SB_req_i & !flush_i & rs1_free & rs2_free & rd_room;

   assign claim    = grant & ID_SB_rd_we_i & (ID_SB_rd_i != 5'd0) & (int'(ID_SB_rd_i) < NTRK);
   assign rel_req  = WB_SB_release_i & (WB_SB_rd_i != 5'd0);
   assign rel_cnt  = cnt_of(WB_SB_rd_i);
   assign rel_ok   = rel_req & (rel_cnt != '0);
   assign rel_err  = rel_req & (rel_cnt == '0);

   always_comb begin
      for (int i = 0; i < NTRK; i++) begin
         cnt_d[i] = cnt_q[i];
         if (flush_i)
            cnt_d[i] = '0;
         else if (claim && ID_SB_rd_i == 5'(i) && !(rel_ok && WB_SB_rd_i == 5'(i)))
            cnt_d[i] = cnt_q[i] + 1'b1;
         else if (rel_ok && WB_SB_rd_i == 5'(i) && !(claim && ID_SB_rd_i == 5'(i)))
            cnt_d[i] = cnt_q[i] - 1'b1;
      end
   end

   always_comb begin
      pending_d = pending_q;
      err_d     = err_q;
      if (flush_i) begin
         pending_d = '0;
      end else begin
         if (claim && !rel_ok) begin
            if (pending_q == PEND_MAX)
               err_d = 1'b1;
            else
               pending_d = pending_q + 1'b1;
         end else if (rel_ok && !claim) begin
            if (pending_q != '0)
               pending_d = pending_q - 1'b1;
         end
         if (rel_err)
            err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn_i) begin
      if (!resetn_i) begin
         for (int i = 0; i < NTRK; i++)
            cnt_q[i] <= '0;
         pending_q <= '0;
         err_q     <= 1'b0;
      end else begin
         for (int i = 0; i < NTRK; i++)
            cnt_q[i] <= cnt_d[i];
         pending_q <= pending_d;
         err_q     <= err_d;
      end
   end

   assign SB_ID_access_o = grant;
   assign pending_o      = pending_q;
   assign err_o          = err_q;

endmodule
